// File: rtl/regfile_init_ctrl.sv
// Write-port sequencer for the 32x32 register unit: walks x1..x31 with known
// values after reset or on request, otherwise passes writeback writes straight through.
module regfile_init_ctrl #(
    parameter logic [31:0] SP_INIT  = 32'h0000_0200,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_req_i,
    input  logic        pipe_RUWr_i,
    input  logic [4:0]  pipe_Rd_i,
    input  logic [31:0] pipe_DataWr_i,
    output logic        RUWr_o,
    output logic [4:0]  Rd_o,
    output logic [31:0] DataWr_o,
    output logic        busy_o,
    output logic        init_done_o
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        done_q, done_d;

    // State, walk index and completion flag registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            idx_q   <= 5'd1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Next-state sequencing; init_req is only honoured in RUN so a walk never restarts or queues
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            CLEAR: begin
                if (idx_q == 5'd31) begin
                    state_d = RUN;
                    idx_d   = 5'd1;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 5'd1;
                end
            end
            RUN: begin
                if (init_req_i) begin
                    state_d = CLEAR;
                    idx_d   = 5'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = CLEAR;
                idx_d   = 5'd1;
            end
        endcase
    end

    // Write-port mux; reset forces a quiet port and a held stall
    always_comb begin
        RUWr_o      = 1'b0;
        Rd_o        = 5'd0;
        DataWr_o    = 32'd0;
        busy_o      = 1'b1;
        init_done_o = 1'b0;
        if (rst_i) begin
            busy_o = 1'b1;
        end else begin
            init_done_o = done_q;
            case (state_q)
                CLEAR: begin
                    RUWr_o   = 1'b1;
                    Rd_o     = idx_q;
                    DataWr_o = (idx_q == 5'd2) ? SP_INIT : INIT_VAL;
                    busy_o   = 1'b1;
                end
                RUN: begin
                    RUWr_o   = pipe_RUWr_i;
                    Rd_o     = pipe_Rd_i;
                    DataWr_o = pipe_DataWr_i;
                    busy_o   = 1'b0;
                end
                default: begin
                    busy_o = 1'b1;
                end
            endcase
        end
    end

endmodule
